// File: rtl/store_trace_fifo.sv
// store_trace_fifo
//   Captures every data-memory store of the multicycle processor into a small
//   first-word-fall-through FIFO that a downstream consumer drains through a
//   valid/ready handshake. The processor is never stalled: stores that arrive
//   while the FIFO is full (and not being popped) are dropped and counted.
//
//   Optional feature: define STORE_TRACE_FILTER_EN to capture only stores whose
//   address lies in [LO_ADR, HI_ADR] (unsigned). Out-of-window stores are
//   ignored and never counted as drops. When undefined, every store is a push
//   request and LO_ADR/HI_ADR have no effect.
//
// Parameters
//   DEPTH   number of entries (power of two, >= 2)
//   DROPW   width of the saturating drop counter
//   LO_ADR  lowest captured address (filter build only)
//   HI_ADR  highest captured address (filter build only)
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   asynchronous, active-low; clears pointers/flags/array
//   MemWrite    in   processor store strobe, one store per high cycle
//   Adr         in   store address
//   WriteData   in   store data
//   TraceReady  in   consumer accepts the head entry
//   TraceValid  out  FIFO non-empty
//   TraceAdr    out  head-entry address
//   TraceData   out  head-entry data
//   Count       out  occupancy, 0..DEPTH
//   Overflow    out  sticky, set on the first dropped store
//   DropCount   out  number of dropped stores, saturating
module store_trace_fifo #(
  parameter int          DEPTH  = 8,
  parameter int          DROPW  = 8,
  parameter logic [31:0] LO_ADR = 32'h0000_0000,
  parameter logic [31:0] HI_ADR = 32'hFFFF_FFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic [31:0]                Adr,
  input  logic [31:0]                WriteData,
  input  logic                       TraceReady,
  output logic                       TraceValid,
  output logic [31:0]                TraceAdr,
  output logic [31:0]                TraceData,
  output logic [$clog2(DEPTH+1)-1:0] Count,
  output logic                       Overflow,
  output logic [DROPW-1:0]           DropCount
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [DROPW-1:0] DROP_MAX = '1;

  logic [63:0]      mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d;
  logic [AW-1:0]    rp_q, rp_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [DROPW-1:0] drop_q, drop_d;

  logic push_req;
  logic pop;
  logic full;
  logic push_acc;
  logic push_rej;

`ifdef STORE_TRACE_FILTER_EN
  // Window test done with 33-bit differences so the borrow bit gives an
  // unsigned compare without constant-comparison warnings at the defaults.
  logic [32:0] lo_diff;
  logic [32:0] hi_diff;
  logic        in_win;

  assign lo_diff  = {1'b0, Adr} - {1'b0, LO_ADR};
  assign hi_diff  = {1'b0, HI_ADR} - {1'b0, Adr};
  assign in_win   = ~lo_diff[32] & ~hi_diff[32];
  assign push_req = MemWrite & in_win;
`else
  // Keeps the window parameters referenced when the filter is compiled out.
  logic unused_win;

  assign unused_win = ^{LO_ADR, HI_ADR};
  assign push_req   = MemWrite;
`endif

  assign TraceValid = (count_q != '0);
  assign full       = (count_q == FULL_CNT);
  assign pop        = TraceValid & TraceReady;
  // When full, a same-cycle pop frees the slot the new entry lands in.
  assign push_acc   = push_req & (~full | pop);
  assign push_rej   = push_req & full & ~pop;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;

    if (push_acc) wp_d = wp_q + AW'(1);
    if (pop)      rp_d = rp_q + AW'(1);

    if (push_acc && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push_acc) count_d = count_q - CW'(1);

    if (push_rej) begin
      ovf_d = 1'b1;
      if (drop_q != DROP_MAX) drop_d = drop_q + DROPW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
    end
  end

  // Array is zeroed on reset so the head outputs are never X.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_acc) begin
      mem_q[wp_q] <= {Adr, WriteData};
    end
  end

  assign TraceAdr  = mem_q[rp_q][63:32];
  assign TraceData = mem_q[rp_q][31:0];
  assign Count     = count_q;
  assign Overflow  = ovf_q;
  assign DropCount = drop_q;

endmodule
